// File: rtl/guard_add_pkg.sv
// Shared types and constants for the guarded-adder scheduler.
// Imported by guard_add_sched and rr_pick.
package guard_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int          DW_DEF   = 32;
    localparam int          STAT_W   = 32;
    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/guard_add_sched_rr_pick.sv
// Combinational round-robin select: first valid requester
// at or after the pointer, searching with wrap-around.
module rr_pick
    import guard_add_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Rotating priority scan starting at the pointer
    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!o_any && i_valid[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/guard_add_sched.sv
// Round-robin scheduler sharing one operand-guarded adder.
// Optional macro GUARD_ADD_STATS_EN adds stat_active/stat_idle counters.
module guard_add_sched
    import guard_add_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DW_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DW-1:0]        req_a,
    input  logic [N_REQ*DW-1:0]        req_b,
    output logic                       guard_en,
    output logic [DW-1:0]              op_a,
    output logic [DW-1:0]              op_b,
    input  logic [DW:0]                add_sum,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DW:0]                rsp_sum,
    output logic [$clog2(N_REQ)-1:0]   rsp_id
`ifdef GUARD_ADD_STATS_EN
    ,
    output logic [STAT_W-1:0]          stat_active,
    output logic [STAT_W-1:0]          stat_idle
`endif
);

    localparam int ID_W = $clog2(N_REQ);

    state_t            r_state;
    state_t            w_next;
    logic              w_grant;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_idx;
    logic              w_any;
    logic [DW-1:0]     r_op_a;
    logic [DW-1:0]     r_op_b;
    logic [DW:0]       r_sum;
    logic [ID_W-1:0]   r_id;
    logic [DW-1:0]     w_sel_a;
    logic [DW-1:0]     w_sel_b;

    rr_pick #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_a   = req_a[int'(w_idx)*DW +: DW];
    assign w_sel_b   = req_b[int'(w_idx)*DW +: DW];
    assign w_ptr_nxt = (w_idx == ID_W'(N_REQ - 1)) ? '0
                     : w_idx + ID_W'(1);

    // Next-state logic; grants are only taken in IDLE
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: w_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign req_ready = w_grant ? w_gnt : '0;
    assign guard_en  = (r_state == ISSUE);
    assign rsp_valid = (r_state == RESP);
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign rsp_sum   = r_sum;
    assign rsp_id    = r_id;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operands move only on a grant so the adder inputs stay quiet
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
            r_sum  <= '0;
        end else begin
            if (w_grant) begin
                r_op_a <= w_sel_a;
                r_op_b <= w_sel_b;
                r_id   <= w_idx;
                r_ptr  <= w_ptr_nxt;
            end
            if (r_state == ISSUE) begin
                r_sum <= add_sum;
            end
        end
    end

`ifdef GUARD_ADD_STATS_EN
    logic [STAT_W-1:0] r_stat_active;
    logic [STAT_W-1:0] r_stat_idle;

    // Saturating activity / idle counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_active <= '0;
            r_stat_idle   <= '0;
        end else begin
            if (guard_en && (r_stat_active != STAT_MAX)) begin
                r_stat_active <= r_stat_active + STAT_W'(1);
            end
            if ((r_state == IDLE) && !(|req_valid)
                && (r_stat_idle != STAT_MAX)) begin
                r_stat_idle <= r_stat_idle + STAT_W'(1);
            end
        end
    end

    assign stat_active = r_stat_active;
    assign stat_idle   = r_stat_idle;
`endif

endmodule

// File: tb/tb_guard_add_sched.sv
// Self-checking bench for guard_add_sched.
// Build with +define+GUARD_ADD_STATS_EN to exercise the counters.
module tb_guard_add_sched;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    wire  [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    wire          guard_en;
    wire  [31:0]  op_a;
    wire  [31:0]  op_b;
    logic [32:0]  add_sum;
    wire          rsp_valid;
    logic         rsp_ready;
    wire  [32:0]  rsp_sum;
    wire  [1:0]   rsp_id;
`ifdef GUARD_ADD_STATS_EN
    wire  [31:0]  stat_active;
    wire  [31:0]  stat_idle;
`endif

    int checks;
    int failures;
    int mdl_ptr;

    guard_add_sched #(
        .N_REQ (4),
        .DW    (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .guard_en  (guard_en),
        .op_a      (op_a),
        .op_b      (op_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef GUARD_ADD_STATS_EN
        ,
        .stat_active (stat_active),
        .stat_idle   (stat_idle)
`endif
    );

    // External guarded adder: junk when not enabled
    assign add_sum = guard_en ? ({1'b0, op_a} + {1'b0, op_b})
                              : 33'h0_DEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Round-robin reference: first set bit at or after p
    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = $urandom;
            req_b[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) tick();
        rst_n   = 1'b1;
        mdl_ptr = 0;
    endtask

    task automatic wait_grant(input int budget, output int cyc,
                              output logic [3:0] g);
        cyc = 0;
        g   = '0;
        for (int i = 0; i < budget; i++) begin
            samp();
            cyc++;
            if (req_ready != 4'b0) begin
                g = req_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rand_ops();
        do_reset();
        samp();
        checks++;
        if ({req_ready, guard_en, rsp_valid, op_a, op_b,
             rsp_sum, rsp_id} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rr=%b ge=%b rv=%b a=%h b=%h s=%h id=%0d exp all 0",
                     req_ready, guard_en, rsp_valid, op_a, op_b,
                     rsp_sum, rsp_id);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            rand_ops();
            samp();
            checks++;
            if (guard_en !== 1'b0 || op_a !== 32'h0
                || op_b !== 32'h0 || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_quiet cyc=%0d got ge=%b a=%h b=%h rv=%b exp 0",
                         i, guard_en, op_a, op_b, rsp_valid);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req_a[2*32 +: 32] = 32'hFFFF_FFFF;
        req_b[2*32 +: 32] = 32'h0000_0001;
        req_valid = 4'b0100;
        samp();
        checks++;
        if (req_ready !== 4'b0100 || guard_en !== 1'b0) begin
            failures++;
            $display("FAIL single_grant got rr=%b ge=%b exp 0100/0",
                     req_ready, guard_en);
        end
        tick();
        req_valid = '0;
        samp();
        checks++;
        if (guard_en !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_issue got ge=%b rv=%b exp 1/0",
                     guard_en, rsp_valid);
        end
        tick();
        samp();
        checks++;
        if (guard_en !== 1'b0 || rsp_valid !== 1'b1
            || rsp_sum !== 33'h1_0000_0000 || rsp_id !== 2'd2) begin
            failures++;
            $display("FAIL single_resp got ge=%b rv=%b sum=%h id=%0d exp 0/1/100000000/2",
                     guard_en, rsp_valid, rsp_sum, rsp_id);
        end
        tick();
        samp();
        checks++;
        if (rsp_valid !== 1'b0 || guard_en !== 1'b0
            || req_ready !== 4'b0) begin
            failures++;
            $display("FAIL single_done got rv=%b ge=%b rr=%b exp 0",
                     rsp_valid, guard_en, req_ready);
        end
        tick();
    endtask

    task automatic test_wrap();
        int          cyc;
        logic [3:0]  g;
        do_reset();
        rand_ops();
        req_valid = 4'b1000;
        samp();
        tick();
        req_valid = 4'b0001;
        wait_grant(6, cyc, g);
        checks++;
        if (g !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_grant0 got %b exp 0001", g);
        end
        tick();
        req_valid = 4'b1111;
        wait_grant(6, cyc, g);
        checks++;
        if (g !== 4'b0010) begin
            failures++;
            $display("FAIL wrap_next got %b exp 0010", g);
        end
        tick();
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_fairness();
        int          cyc;
        logic [3:0]  g;
        logic [3:0]  e;
        do_reset();
        rand_ops();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(6, cyc, g);
            e = 4'b0001 << (i % 4);
            checks++;
            if (g !== e || cyc != ((i == 0) ? 1 : 3)) begin
                failures++;
                $display("FAIL fair_order n=%0d got %b gap=%0d exp %b gap=%0d",
                         i, g, cyc, e, (i == 0) ? 1 : 3);
            end
        end
        tick();
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        int           r;
        int           nxt;
        logic [32:0]  es;
        logic [32:0]  hs;
        logic [1:0]   hid;
        do_reset();
        rand_ops();
        r = $urandom_range(0, 3);
        req_valid = 4'b0001 << r;
        rsp_ready = 1'b0;
        es = {1'b0, req_a[r*32 +: 32]} + {1'b0, req_b[r*32 +: 32]};
        samp();
        tick();
        req_valid = 4'b1111;
        samp();
        tick();
        samp();
        hs  = rsp_sum;
        hid = rsp_id;
        checks++;
        if (rsp_valid !== 1'b1 || hs !== es || hid !== 2'(r)) begin
            failures++;
            $display("FAIL bp_resp got rv=%b sum=%h id=%0d exp 1/%h/%0d",
                     rsp_valid, hs, hid, es, r);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            samp();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== hs || rsp_id !== hid
                || req_ready !== 4'b0 || guard_en !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got rv=%b sum=%h id=%0d rr=%b ge=%b exp 1/%h/%0d/0/0",
                         i, rsp_valid, rsp_sum, rsp_id, req_ready,
                         guard_en, hs, hid);
            end
        end
        tick();
        rsp_ready = 1'b1;
        samp();
        checks++;
        if (req_ready !== 4'b0) begin
            failures++;
            $display("FAIL bp_same_cycle got rr=%b exp 0000", req_ready);
        end
        tick();
        samp();
        nxt = pick(4'b1111, (r + 1) % 4);
        checks++;
        if (req_ready !== (4'b0001 << nxt)) begin
            failures++;
            $display("FAIL bp_regrant got rr=%b exp %b",
                     req_ready, 4'b0001 << nxt);
        end
        tick();
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_mid_reset();
        int r;
        do_reset();
        rand_ops();
        r = $urandom_range(1, 3);
        req_valid = 4'b0001 << r;
        samp();
        tick();
        req_valid = '0;
        samp();
        checks++;
        if (guard_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_issue got ge=%b exp 1", guard_en);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        samp();
        checks++;
        if ({req_ready, guard_en, rsp_valid, op_a, op_b,
             rsp_sum, rsp_id} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got rr=%b ge=%b rv=%b a=%h b=%h s=%h id=%0d exp all 0",
                     req_ready, guard_en, rsp_valid, op_a, op_b,
                     rsp_sum, rsp_id);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            samp();
            checks++;
            if (rsp_valid !== 1'b0 || guard_en !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_resp cyc=%0d got rv=%b ge=%b exp 0",
                         i, rsp_valid, guard_en);
            end
        end
        tick();
        req_valid = 4'b1111;
        samp();
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_ptr_reset got rr=%b exp 0001", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [3:0]   m;
        int           e;
        int           d;
        logic [31:0]  ea;
        logic [31:0]  eb;
        logic [32:0]  es;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            m = 4'($urandom);
            rand_ops();
            req_valid = m;
            samp();
            e = pick(m, mdl_ptr);
            if (e < 0) begin
                checks++;
                if (req_ready !== 4'b0 || guard_en !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_nogrant n=%0d got rr=%b ge=%b exp 0",
                             n, req_ready, guard_en);
                end
                tick();
                continue;
            end
            checks++;
            if (req_ready !== (4'b0001 << e)) begin
                failures++;
                $display("FAIL rnd_grant n=%0d got %b exp %b",
                         n, req_ready, 4'b0001 << e);
            end
            mdl_ptr = (e + 1) % 4;
            ea = req_a[e*32 +: 32];
            eb = req_b[e*32 +: 32];
            es = {1'b0, ea} + {1'b0, eb};
            tick();
            req_valid = 4'($urandom);
            rand_ops();
            d = $urandom_range(0, 2);
            rsp_ready = (d == 0);
            samp();
            checks++;
            if (guard_en !== 1'b1 || op_a !== ea || op_b !== eb
                || req_ready !== 4'b0) begin
                failures++;
                $display("FAIL rnd_issue n=%0d got ge=%b a=%h b=%h rr=%b exp 1/%h/%h/0",
                         n, guard_en, op_a, op_b, req_ready, ea, eb);
            end
            tick();
            samp();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== es
                || rsp_id !== 2'(e) || guard_en !== 1'b0
                || req_ready !== 4'b0) begin
                failures++;
                $display("FAIL rnd_resp n=%0d got rv=%b sum=%h id=%0d ge=%b rr=%b exp 1/%h/%0d/0/0",
                         n, rsp_valid, rsp_sum, rsp_id, guard_en,
                         req_ready, es, e);
            end
            for (int k = 0; k < d; k++) begin
                tick();
                if (k == d - 1) rsp_ready = 1'b1;
                samp();
                checks++;
                if (rsp_valid !== 1'b1 || rsp_sum !== es
                    || req_ready !== 4'b0) begin
                    failures++;
                    $display("FAIL rnd_stall n=%0d got rv=%b sum=%h rr=%b exp 1/%h/0",
                             n, rsp_valid, rsp_sum, req_ready, es);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

`ifdef GUARD_ADD_STATS_EN
    task automatic test_stats();
        int          cyc;
        logic [3:0]  g;
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        rand_ops();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_grant(6, cyc, g);
            checks++;
            if (g !== 4'b0001) begin
                failures++;
                $display("FAIL stats_grant n=%0d got %b exp 0001", i, g);
            end
        end
        tick();
        req_valid = '0;
        samp();
        tick();
        samp();
        repeat (5) samp();
        checks++;
        if (stat_active !== 32'd3 || stat_idle !== 32'd4) begin
            failures++;
            $display("FAIL stats_count got act=%0d idle=%0d exp 3/4",
                     stat_active, stat_idle);
        end
        tick();
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        mdl_ptr   = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef GUARD_ADD_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
